dift_tag_init_engine: RTL and testbench

Hardware tag initializer for the DIFT extension. On a start command it sweeps a word-aligned address range as a TCDM master on an `XBAR_TCDM_BUS_36` port. For every word it writes a programmed 4-bit tag into bits [35:32] and, when read-modify-write is compiled in, preserves data bits [31:0]. It sits beside the read-path tag override and makes tag initialization persistent in memory instead of applying it on every read.

---
 rtl/dift_tag_init_engine.sv | 154 +++++++++++++++
 tb/tb_dift_tag_init_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dift_tag_init_engine.sv
// DIFT tag initializer: sweeps [start, end) word by word over a TCDM master port writing a tag into bits [35:32].
// Define DIFT_TAG_INIT_RMW_EN to keep data bits [31:0] (read-modify-write); otherwise they are written as zero.
module dift_tag_init_engine #(
   parameter int unsigned TAG_BITS_NUM = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [31:0]                  start_addr_i,
   input  logic [31:0]                  end_addr_i,
   input  logic [TAG_BITS_NUM-1:0]      tag_value_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [29:0]                  words_o,
   output logic                         master_req_o,
   output logic [31:0]                  master_add_o,
   output logic                         master_wen_o,
   output logic [3:0]                   master_be_o,
   output logic [32+TAG_BITS_NUM-1:0]   master_wdata_o,
   input  logic                         master_gnt_i,
   input  logic                         master_r_valid_i,
   input  logic [32+TAG_BITS_NUM-1:0]   master_r_rdata_i,
   input  logic                         master_r_opc_i
);

   // state     | meaning
   // S_IDLE    | waiting for start_i
   // S_RD_REQ  | read request for cur_q, held until gnt
   // S_RD_WAIT | waiting for read response, captures data
   // S_WR_REQ  | write request {tag, data} for cur_q, held until gnt
   // S_WR_WAIT | waiting for write response, advances address
   // S_DONE    | one-cycle completion pulse
   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
   } state_e;

`ifdef DIFT_TAG_INIT_RMW_EN
   localparam state_e S_FIRST = S_RD_REQ;
`else
   localparam state_e S_FIRST = S_WR_REQ;
`endif

   state_e                    state_q, state_d;
   logic [31:0]               cur_q, cur_d;
   logic [31:0]               end_q, end_d;
   logic [TAG_BITS_NUM-1:0]   tag_q, tag_d;
   logic [29:0]               words_q, words_d;
   logic                      err_q, err_d;
   logic [31:0]               start_word, end_word;
   logic [32:0]               next_addr;
   logic                      unused_bits;

`ifdef DIFT_TAG_INIT_RMW_EN
   logic [31:0]               data_q, data_d;
   assign unused_bits = ^{master_r_rdata_i[32+TAG_BITS_NUM-1:32], start_addr_i[1:0], end_addr_i[1:0]};
`else
   assign unused_bits = ^{master_r_rdata_i, start_addr_i[1:0], end_addr_i[1:0]};
`endif

   assign start_word = {start_addr_i[31:2], 2'b00};
   assign end_word   = {end_addr_i[31:2], 2'b00};
   // The carry bit catches a wrap past 32'hFFFF_FFFC.
   assign next_addr  = {1'b0, cur_q} + 33'd4;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      end_d   = end_q;
      tag_d   = tag_q;
      words_d = words_q;
      err_d   = err_q;
`ifdef DIFT_TAG_INIT_RMW_EN
      data_d  = data_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cur_d   = start_word;
               end_d   = end_word;
               tag_d   = tag_value_i;
               words_d = '0;
               err_d   = 1'b0;
               state_d = (start_word < end_word) ? S_FIRST : S_DONE;
            end
         end
`ifdef DIFT_TAG_INIT_RMW_EN
         S_RD_REQ: begin
            if (master_gnt_i) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (master_r_valid_i) begin
               data_d  = master_r_rdata_i[31:0];
               err_d   = err_q | master_r_opc_i;
               state_d = S_WR_REQ;
            end
         end
`endif
         S_WR_REQ: begin
            if (master_gnt_i) state_d = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (master_r_valid_i) begin
               err_d   = err_q | master_r_opc_i;
               words_d = words_q + 30'd1;
               cur_d   = next_addr[31:0];
               if (next_addr[32] || (next_addr[31:0] >= end_q)) state_d = S_DONE;
               else                                             state_d = S_FIRST;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         tag_q   <= '0;
         words_q <= '0;
         err_q   <= 1'b0;
`ifdef DIFT_TAG_INIT_RMW_EN
         data_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         tag_q   <= tag_d;
         words_q <= words_d;
         err_q   <= err_d;
`ifdef DIFT_TAG_INIT_RMW_EN
         data_q  <= data_d;
`endif
      end
   end

   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
   assign err_o        = err_q;
   assign words_o      = words_q;
   assign master_req_o = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
   assign master_add_o = cur_q;
   assign master_wen_o = (state_q != S_WR_REQ);
   assign master_be_o  = 4'hF;
`ifdef DIFT_TAG_INIT_RMW_EN
   assign master_wdata_o = (state_q == S_WR_REQ) ? {tag_q, data_q} : '0;
`else
   assign master_wdata_o = (state_q == S_WR_REQ) ? {tag_q, 32'h0} : '0;
`endif

endmodule

// File: tb/tb_dift_tag_init_engine.sv
// Directed bench for dift_tag_init_engine: a vector table of sweeps against a small TCDM memory model.
module tb_dift_tag_init_engine;

   localparam logic [31:0] B = 32'h1C00_0000;
`ifdef DIFT_TAG_INIT_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif

   logic        clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic        rst_i, start_i;
   logic [31:0] start_addr_i, end_addr_i;
   logic [3:0]  tag_value_i;
   logic        busy_o, done_o, err_o;
   logic [29:0] words_o;
   logic        req, wen, gnt, r_valid, r_opc;
   logic [31:0] add;
   logic [3:0]  be;
   logic [35:0] wdata, r_rdata;

   dift_tag_init_engine #(.TAG_BITS_NUM(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .tag_value_i(tag_value_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o),
      .master_req_o(req), .master_add_o(add), .master_wen_o(wen), .master_be_o(be),
      .master_wdata_o(wdata), .master_gnt_i(gnt), .master_r_valid_i(r_valid),
      .master_r_rdata_i(r_rdata), .master_r_opc_i(r_opc)
   );

   typedef struct {
      logic [31:0] sa;
      logic [31:0] ea;
      logic [3:0]  tag;
      logic [35:0] pre;
      int          stall;
      int          opc_rmw;
      int          opc_wo;
      bit          poke;
      int          words;
      int          cyc_rmw;
      int          cyc_wo;
      bit          err;
      logic [35:0] d_rmw;
      logic [35:0] d_wo;
   } vec_t;

   vec_t        vecs [8];
   logic [35:0] mem [64];
   int          checks, errors, cyc;
   int          stall_left, max_stall, resp_idx, opc_resp, req_cycles, done_hi;
   bit          hold_valid, last_acc, acc_wen;
   logic [5:0]  acc_idx;
   logic [35:0] acc_wdata, h_wdata;
   logic [31:0] h_add;
   logic        h_wen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory model, evaluated once per falling edge: completes the access granted at the
   // previous rising edge (response one cycle after gnt) and decides gnt for the next one.
   task automatic mem_step();
      if (rst_i) begin
         gnt = 1'b0; r_valid = 1'b0; r_opc = 1'b0;
         hold_valid = 1'b0; last_acc = 1'b0;
         return;
      end
      r_valid = 1'b0;
      r_opc   = 1'b0;
      if (last_acc) begin
         if (!acc_wen) mem[acc_idx] = acc_wdata;
         r_rdata = mem[acc_idx];
         r_valid = 1'b1;
         r_opc   = (resp_idx == opc_resp);
         resp_idx++;
      end
      if (hold_valid) begin
         chk("req_held", req, 1);
         chk("add_stable", add, h_add);
         chk("wen_stable", wen, h_wen);
         chk("wdata_stable", wdata, h_wdata);
      end
      hold_valid = 1'b0;
      gnt = 1'b0;
      if (req) begin
         req_cycles++;
         if (stall_left > 0) begin
            stall_left--;
            hold_valid = 1'b1;
            h_add = add; h_wen = wen; h_wdata = wdata;
         end else begin
            gnt = 1'b1;
            stall_left = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
         end
      end
      last_acc  = req && gnt;
      acc_idx   = add[7:2];
      acc_wen   = wen;
      acc_wdata = wdata;
   endtask

   task automatic tick();
      @(negedge clk_i);
      cyc++;
      mem_step();
      if (done_o) done_hi++;
   endtask

   task automatic preload(input logic [35:0] v);
      for (int i = 0; i < 64; i++) mem[i] = v;
   endtask

   task automatic run(input vec_t v);
      int          t0, d0, r0, n, exp_c;
      logic [35:0] exp_d;
      logic [31:0] a;
      exp_d    = RMW ? v.d_rmw : v.d_wo;
      exp_c    = RMW ? v.cyc_rmw : v.cyc_wo;
      opc_resp = RMW ? v.opc_rmw : v.opc_wo;
      preload(v.pre);
      max_stall = v.stall; stall_left = 0; resp_idx = 0;
      d0 = done_hi; r0 = req_cycles;
      start_addr_i = v.sa; end_addr_i = v.ea; tag_value_i = v.tag; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      t0 = cyc;
      chk("busy_rise", busy_o, 1);
      chk("err_cleared", err_o, 0);
      chk("words_cleared", words_o, 0);
      n = 0;
      while (!done_o && n < 400) begin
         if (v.poke && n == 2) begin
            start_i = 1'b1; start_addr_i = 32'h0; end_addr_i = B + 32'h100; tag_value_i = 4'h9;
         end else begin
            start_i = 1'b0;
         end
         tick();
         n++;
      end
      start_i = 1'b0;
      chk("done_seen", done_o, 1);
      if (exp_c >= 0) chk("cycles", cyc - t0, exp_c);
      chk("words", words_o, v.words);
      chk("err", err_o, v.err);
      tick();
      tick();
      chk("done_pulses", done_hi - d0, 1);
      chk("busy_after", busy_o, 0);
      if (v.words == 0) begin
         chk("no_req", req_cycles - r0, 0);
      end else begin
         a = {v.sa[31:2], 2'b00};
         for (int k = 0; k < v.words; k++) begin
            chk("mem_word", mem[a[7:2]], exp_d);
            a = a + 32'd4;
         end
         chk("mem_after", mem[a[7:2]], v.pre);
         a = {v.sa[31:2], 2'b00} - 32'd4;
         chk("mem_before", mem[a[7:2]], v.pre);
      end
   endtask

   initial begin
      bit found;
      checks = 0; errors = 0; cyc = 0; req_cycles = 0; done_hi = 0;
      stall_left = 0; max_stall = 0; resp_idx = 0; opc_resp = -1;
      hold_valid = 1'b0; last_acc = 1'b0; acc_wen = 1'b1; acc_idx = '0;
      acc_wdata = '0; h_wdata = '0; h_add = '0; h_wen = 1'b1;
      rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0; end_addr_i = '0; tag_value_i = '0;
      gnt = 1'b0; r_valid = 1'b0; r_opc = 1'b0; r_rdata = '0;
      preload(36'h0);

      //        sa            ea              tag    pre            stl opcR opcW poke wrd cR  cW  err d_rmw           d_wo
      vecs[0] = '{B,            B + 32'h10,     4'hF, 36'h0_DEADBEEF, 0, -1, -1, 1'b0, 4, 16,  8, 1'b0, 36'hF_DEADBEEF, 36'hF_00000000};
      vecs[1] = '{B + 32'h100,  B + 32'h100,    4'h3, 36'h0_DEADBEEF, 0, -1, -1, 1'b0, 0,  0,  0, 1'b0, 36'h0,          36'h0};
      vecs[2] = '{B,            B + 32'h10,     4'hF, 36'h0_DEADBEEF, 5, -1, -1, 1'b0, 4, -1, -1, 1'b0, 36'hF_DEADBEEF, 36'hF_00000000};
      vecs[3] = '{B + 32'h40,   B + 32'h50,     4'hA, 36'h0_11111111, 0,  2,  1, 1'b0, 4, 16,  8, 1'b1, 36'hA_11111111, 36'hA_00000000};
      vecs[4] = '{B + 32'h21,   B + 32'h2E,     4'h5, 36'h0_12345678, 0, -1, -1, 1'b1, 3, 12,  6, 1'b0, 36'h5_12345678, 36'h5_00000000};
      vecs[5] = '{B + 32'h40,   B + 32'h20,     4'h7, 36'h0_DEADBEEF, 0, -1, -1, 1'b0, 0,  0,  0, 1'b0, 36'h0,          36'h0};
      vecs[6] = '{B + 32'h80,   B + 32'h88,     4'h0, 36'h3_CAFEF00D, 0, -1, -1, 1'b0, 2,  8,  4, 1'b0, 36'h0_CAFEF00D, 36'h0_00000000};
      vecs[7] = '{32'hFFFFFFF8, 32'hFFFFFFFF,   4'hC, 36'h0_0BADF00D, 2, -1, -1, 1'b0, 1, -1, -1, 1'b0, 36'hC_0BADF00D, 36'hC_00000000};

      tick(); tick(); tick();
      chk("rst_req", req, 0);
      chk("rst_wen", wen, 1);
      chk("rst_be", be, 4'hF);
      chk("rst_add", add, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_words", words_o, 0);
      rst_i = 1'b0;
      tick();

      for (int v = 0; v < 8; v++) run(vecs[v]);

      // Reset asserted while the write of the third word is being requested.
      preload(36'h0_DEADBEEF);
      max_stall = 0; stall_left = 0; resp_idx = 0; opc_resp = -1;
      start_addr_i = B; end_addr_i = B + 32'h10; tag_value_i = 4'hF; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         tick();
         if (req && !wen && add == B + 32'h8) begin
            found = 1'b1;
            break;
         end
      end
      chk("rst_point_found", found, 1);
      rst_i = 1'b1;
      #1;
      chk("midrst_req", req, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_words", words_o, 0);
      tick();
      chk("midrst_req_next", req, 0);
      chk("midrst_busy_next", busy_o, 0);
      chk("midrst_words_next", words_o, 0);
      rst_i = 1'b0;
      tick();
      run(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
